userdma_dataflow_ctrl: RTL and testbench
========================================

Name: userdma_dataflow_ctrl

Overview:
- Top-level sequencer for the userdma dataflow region.
- Stages: entry_proc, getinstream, streamtoparallelwithburst, paralleltostreamwithburst, sendoutstream.
- Accepts one kernel launch (ap_ctrl_chain style), latches mode/length, issues per-stage start, acknowledges per-stage done with continue, and reports a single kernel done.
- Sits between the AXI-Lite control slave and the stage processes.

Parameters:
- NUM_STAGES, 5, number of controlled stages. Bit i maps to stage i in the order listed in Overview.
- CNT_W, 32, width of the transfer-length field.
- S2MM_MASK, 5'b00111, stages launched when mode bit0 (stream-to-memory) is set.
- MM2S_MASK, 5'b11001, stages launched when mode bit1 (memory-to-stream) is set.
- WDOG_CYCLES, 4096, stall threshold in cycles. Used only with the optional feature.

Ports:
- ap_clk  in  1  clock
- ap_rst_n  in  1  asynchronous active-low reset
- ap_start  in  1  kernel launch request
- ap_ready  out  1  one-cycle pulse: launch fully accepted
- ap_done  out  1  kernel complete; held until ap_continue
- ap_idle  out  1  controller in IDLE
- ap_continue  in  1  acknowledges ap_done
- cfg_mode  in  2  bit0 S2MM, bit1 MM2S
- cfg_len  in  CNT_W  transfer length in beats
- run_mode  out  2  latched mode
- run_len  out  CNT_W  latched length
- zero_run  out  1  sticky: last launch had no active stage or zero length
- stage_start  out  NUM_STAGES  per-stage ap_start
- stage_ready  in  NUM_STAGES  per-stage ap_ready
- stage_done  in  NUM_STAGES  per-stage ap_done (held until continue)
- stage_continue  out  NUM_STAGES  per-stage ap_continue
- stall_flag  out  1  sticky watchdog expiry
- stall_stages  out  NUM_STAGES  active stages not yet done at expiry

Behaviour:
- Reset values: all outputs 0 except ap_idle=1. FSM goes to IDLE. pending, done_seen and active masks are 0.
- IDLE:
  - ap_idle=1.
  - On ap_start=1, latch cfg_mode/cfg_len into run_mode/run_len.
  - active = (mode[0]?S2MM_MASK:0) | (mode[1]?MM2S_MASK:0).
  - If active==0 or cfg_len==0: set zero_run, pulse ap_ready, go to DONE.
  - Otherwise: clear zero_run, set pending=active, go to RUN.
- RUN:
  - stage_start = pending.
  - pending[i] clears in the cycle stage_ready[i]=1.
  - ap_ready pulses for 1 cycle in the cycle pending becomes 0.
  - stage_continue[i] = stage_done[i] & active[i] & ~done_seen[i], combinational, so done is consumed the same cycle. done_seen[i] sets on that cycle.
  - A stage may assert ready and done in the same cycle; both are recorded.
  - stage_done on an inactive stage is ignored and never continued.
  - When (done_seen & active)==active, go to DONE the next cycle.
- DONE:
  - ap_done=1, ap_idle=0.
  - On ap_continue=1, go to IDLE and clear done_seen/active.
  - ap_start is ignored until IDLE is reached, so there is no launch overlap.
  - ap_continue arriving together with ap_done completes in that cycle.
- Latency, IDLE to first stage_start: 1 cycle.
- Latency, last stage done to ap_done: 1 cycle.
- ap_start held high in IDLE after DONE→IDLE relaunches the next cycle.
- Asynchronous reset in any state aborts immediately. stage_start/continue drop to 0 and there is no completion report.

Optional Feature:
- Macro: USERDMA_CTRL_WATCHDOG_EN.
- When defined:
  - A counter runs in RUN and resets on any stage_ready or stage_continue event.
  - On reaching WDOG_CYCLES-1, set stall_flag and capture stall_stages = active & ~done_seen.
  - Both are sticky until the next accepted ap_start or reset.
  - The FSM is not disturbed.
- When not defined: stall_flag and stall_stages are tied to 0 and no counter is synthesised. The ports remain.

Decomposition:
- Package userdma_ctrl_pkg holds:
  - FSM state enum (IDLE, RUN, DONE).
  - Stage index constants (STG_ENTRY=0 … STG_SEND=4).
  - Default S2MM/MM2S masks.
- One sub-module, userdma_stage_tracker: per-stage pending/done_seen bits plus start/continue generation, instantiated NUM_STAGES times.

Test Plan:
- mode=2'b01, len=256; stages 0,1,2 assert ready in the cycle after start, then done at 10/50/300 cycles later.
  → stage_start[3:4] never high; one ap_ready pulse; ap_done 1 cycle after stage 2 done.
- mode=2'b11, len=64, stage 4 ready delayed 20 cycles.
  → stage_start[4] held 20 cycles; ap_ready pulses exactly once, after stage 4 ready.
- mode=2'b00 or len=0.
  → zero_run=1, ap_ready pulse, ap_done the next cycle, no stage_start.
- ap_continue held low 15 cycles after done, with ap_start held high.
  → ap_done held 15 cycles; relaunch occurs only after IDLE.
- Reset asserted mid-RUN with pending=5'b10000.
  → all outputs return to reset values asynchronously; ap_idle=1.
- With USERDMA_CTRL_WATCHDOG_EN and WDOG_CYCLES=16, stage 2 never done.
  → stall_flag=1 and stall_stages=5'b00100 after 16 idle cycles.

Source files
------------

// File: rtl/userdma_ctrl_pkg.sv
// rtl/userdma_ctrl_pkg.sv - shared state type, stage indices and default launch masks for the userdma sequencer
package userdma_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_state_t;

  localparam int STG_ENTRY   = 0;
  localparam int STG_GETIN   = 1;
  localparam int STG_S2P     = 2;
  localparam int STG_P2S     = 3;
  localparam int STG_SEND    = 4;
  localparam int STAGE_COUNT = STG_SEND + 1;

  localparam logic [STAGE_COUNT-1:0] S2MM_MASK_DEF =
    STAGE_COUNT'((1 << STG_ENTRY) | (1 << STG_GETIN) | (1 << STG_S2P));
  localparam logic [STAGE_COUNT-1:0] MM2S_MASK_DEF =
    STAGE_COUNT'((1 << STG_ENTRY) | (1 << STG_P2S) | (1 << STG_SEND));

endpackage

// File: rtl/userdma_stage_tracker.sv
// rtl/userdma_stage_tracker.sv - per-stage pending/done bookkeeping with ap_start and ap_continue generation
module userdma_stage_tracker (
  input  logic clk,
  input  logic rst_n,
  input  logic launch,
  input  logic stage_en,
  input  logic run,
  input  logic clear,
  input  logic ready,
  input  logic done,
  output logic start,
  output logic cont,
  output logic active,
  output logic pending,
  output logic done_seen
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active    <= 1'b0;
      pending   <= 1'b0;
      done_seen <= 1'b0;
    end else if (clear) begin
      active    <= 1'b0;
      pending   <= 1'b0;
      done_seen <= 1'b0;
    end else if (launch) begin
      active    <= stage_en;
      pending   <= stage_en;
      done_seen <= 1'b0;
    end else begin
      if (run && ready) pending <= 1'b0;
      if (cont) done_seen <= 1'b1;
    end
  end

  // Done is consumed in the cycle it is first seen, so continue is combinational.
  assign start = run & pending;
  assign cont  = done & active & ~done_seen;

endmodule

// File: rtl/userdma_dataflow_ctrl.sv
// rtl/userdma_dataflow_ctrl.sv - ap_ctrl_chain sequencer for the userdma dataflow stages
// Optional stall watchdog enabled by USERDMA_CTRL_WATCHDOG_EN.
module userdma_dataflow_ctrl
  import userdma_ctrl_pkg::*;
#(
  parameter int                    NUM_STAGES  = STAGE_COUNT,
  parameter int                    CNT_W       = 32,
  parameter logic [NUM_STAGES-1:0] S2MM_MASK   = S2MM_MASK_DEF,
  parameter logic [NUM_STAGES-1:0] MM2S_MASK   = MM2S_MASK_DEF,
  parameter int                    WDOG_CYCLES = 4096
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  output logic                  ap_ready,
  output logic                  ap_done,
  output logic                  ap_idle,
  input  logic                  ap_continue,
  input  logic [1:0]            cfg_mode,
  input  logic [CNT_W-1:0]      cfg_len,
  output logic [1:0]            run_mode,
  output logic [CNT_W-1:0]      run_len,
  output logic                  zero_run,
  output logic [NUM_STAGES-1:0] stage_start,
  input  logic [NUM_STAGES-1:0] stage_ready,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [NUM_STAGES-1:0] stage_continue,
  output logic                  stall_flag,
  output logic [NUM_STAGES-1:0] stall_stages
);

  ctrl_state_t           state;
  logic [NUM_STAGES-1:0] cfg_active;
  logic [NUM_STAGES-1:0] active;
  logic [NUM_STAGES-1:0] pending;
  logic [NUM_STAGES-1:0] done_seen;
  logic [NUM_STAGES-1:0] cont_vec;
  logic                  accept;
  logic                  cfg_zero;
  logic                  launch;
  logic                  run;
  logic                  clear;
  logic                  all_done;
  logic                  last_ready;

  assign cfg_active = (cfg_mode[0] ? S2MM_MASK : '0) | (cfg_mode[1] ? MM2S_MASK : '0);
  assign accept     = (state == IDLE) && ap_start;
  assign cfg_zero   = (cfg_active == '0) || (cfg_len == '0);
  assign launch     = accept && !cfg_zero;
  assign run        = (state == RUN);
  assign clear      = (state == DONE) && ap_continue;
  // Include this cycle's continues so ap_done follows the last stage done by one cycle.
  assign all_done   = (((done_seen | cont_vec) & active) == active);
  assign last_ready = (pending != '0) && ((pending & ~stage_ready) == '0);

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    userdma_stage_tracker u_tracker (
      .clk       (ap_clk),
      .rst_n     (ap_rst_n),
      .launch    (launch),
      .stage_en  (cfg_active[i]),
      .run       (run),
      .clear     (clear),
      .ready     (stage_ready[i]),
      .done      (stage_done[i]),
      .start     (stage_start[i]),
      .cont      (cont_vec[i]),
      .active    (active[i]),
      .pending   (pending[i]),
      .done_seen (done_seen[i])
    );
  end

  assign stage_continue = cont_vec;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state    <= IDLE;
      ap_ready <= 1'b0;
      ap_done  <= 1'b0;
      ap_idle  <= 1'b1;
      run_mode <= '0;
      run_len  <= '0;
      zero_run <= 1'b0;
    end else begin
      ap_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (ap_start) begin
            run_mode <= cfg_mode;
            run_len  <= cfg_len;
            ap_idle  <= 1'b0;
            if (cfg_zero) begin
              zero_run <= 1'b1;
              ap_ready <= 1'b1;
              ap_done  <= 1'b1;
              state    <= DONE;
            end else begin
              zero_run <= 1'b0;
              state    <= RUN;
            end
          end
        end
        RUN: begin
          if (last_ready) ap_ready <= 1'b1;
          if (all_done) begin
            ap_done <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (ap_continue) begin
            ap_done <= 1'b0;
            ap_idle <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef USERDMA_CTRL_WATCHDOG_EN
  localparam int WDOG_W = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] wdog_cnt;
  logic              progress;

  assign progress = (|(pending & stage_ready)) | (|cont_vec);

  // Saturates at the threshold so the first capture of the stuck stages is kept.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wdog_cnt     <= '0;
      stall_flag   <= 1'b0;
      stall_stages <= '0;
    end else if (accept) begin
      wdog_cnt     <= '0;
      stall_flag   <= 1'b0;
      stall_stages <= '0;
    end else if (run) begin
      if (progress) begin
        wdog_cnt <= '0;
      end else if (wdog_cnt != WDOG_LAST) begin
        wdog_cnt <= wdog_cnt + 1'b1;
      end else if (!stall_flag) begin
        stall_flag   <= 1'b1;
        stall_stages <= active & ~done_seen;
      end
    end
  end
`else
  assign stall_flag   = 1'b0;
  assign stall_stages = '0;
`endif

endmodule

// File: tb/tb_userdma_dataflow_ctrl.sv
// tb/tb_userdma_dataflow_ctrl.sv - self-checking bench for userdma_dataflow_ctrl with a cycle-timeline reference model
module tb_userdma_dataflow_ctrl;

  localparam logic [4:0] S2MM = 5'b00111;
  localparam logic [4:0] MM2S = 5'b11001;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        ap_start = 1'b0;
  logic        ap_continue = 1'b0;
  logic        ap_ready, ap_done, ap_idle;
  logic [1:0]  cfg_mode = 2'b00;
  logic [31:0] cfg_len = 32'd0;
  logic [1:0]  run_mode;
  logic [31:0] run_len;
  logic        zero_run, stall_flag;
  logic [4:0]  stage_start, stage_continue, stall_stages;
  logic [4:0]  stage_ready = 5'b0;
  logic [4:0]  stage_done = 5'b0;

  int vectors = 0;
  int miscompares = 0;
  int rdly[5];
  int ddly[5];

  userdma_dataflow_ctrl #(
    .NUM_STAGES (5),
    .CNT_W      (32),
    .S2MM_MASK  (S2MM),
    .MM2S_MASK  (MM2S),
    .WDOG_CYCLES(16)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .ap_start      (ap_start),
    .ap_ready      (ap_ready),
    .ap_done       (ap_done),
    .ap_idle       (ap_idle),
    .ap_continue   (ap_continue),
    .cfg_mode      (cfg_mode),
    .cfg_len       (cfg_len),
    .run_mode      (run_mode),
    .run_len       (run_len),
    .zero_run      (zero_run),
    .stage_start   (stage_start),
    .stage_ready   (stage_ready),
    .stage_done    (stage_done),
    .stage_continue(stage_continue),
    .stall_flag    (stall_flag),
    .stall_stages  (stall_stages)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".ap_ready"}, 64'(ap_ready), 64'd0);
    chk({tag, ".ap_done"}, 64'(ap_done), 64'd0);
    chk({tag, ".ap_idle"}, 64'(ap_idle), 64'd1);
    chk({tag, ".run_mode"}, 64'(run_mode), 64'd0);
    chk({tag, ".run_len"}, 64'(run_len), 64'd0);
    chk({tag, ".zero_run"}, 64'(zero_run), 64'd0);
    chk({tag, ".stage_start"}, 64'(stage_start), 64'd0);
    chk({tag, ".stage_continue"}, 64'(stage_continue), 64'd0);
    chk({tag, ".stall_flag"}, 64'(stall_flag), 64'd0);
    chk({tag, ".stall_stages"}, 64'(stall_stages), 64'd0);
  endtask

  // Model: cycle 0 samples ap_start; stage i is started in cycles 1..R(i) with R(i)=1+rdly,
  // raises done at D(i)=R(i)+ddly held three cycles, and is continued only at D(i).
  task automatic run_launch(input logic [1:0] mode, input logic [31:0] len, input int cdly,
                            input bit hold_start, input string tag);
    logic [4:0] act, e_start, e_cont;
    bit zero;
    int r[5], d[5];
    int last_r, last_d, donec, c;
    act = (mode[0] ? S2MM : 5'b0) | (mode[1] ? MM2S : 5'b0);
    zero = (act == 5'b0) || (len == 32'd0);
    last_r = 0;
    last_d = 0;
    for (int i = 0; i < 5; i++) begin
      r[i] = 1 + rdly[i];
      d[i] = r[i] + ddly[i];
      if (act[i] && !zero) begin
        if (r[i] > last_r) last_r = r[i];
        if (d[i] > last_d) last_d = d[i];
      end
    end
    donec = zero ? 1 : last_d + 1;
    c = donec + cdly;
    for (int t = 0; t <= c + 1; t++) begin
      @(posedge ap_clk);
      #1;
      ap_start = (t == 0) || hold_start;
      if (t == 0 || hold_start) begin
        cfg_mode = mode;
        cfg_len  = len;
      end else begin
        cfg_mode = 2'($urandom);
        cfg_len  = $urandom;
      end
      ap_continue = (t == c) || (t > 0 && t < donec && $urandom_range(0, 1) == 1);
      e_start = 5'b0;
      e_cont  = 5'b0;
      for (int i = 0; i < 5; i++) begin
        if (act[i] && !zero) begin
          stage_ready[i] = (t == r[i]);
          stage_done[i]  = (t >= d[i] && t <= d[i] + 2);
          e_start[i]     = (t >= 1 && t <= r[i]);
          e_cont[i]      = (t == d[i]);
        end else begin
          stage_ready[i] = 1'($urandom_range(0, 1));
          stage_done[i]  = 1'($urandom_range(0, 1));
        end
      end
      #3;
      chk({tag, ".stage_start"}, 64'(stage_start), 64'(e_start));
      chk({tag, ".stage_continue"}, 64'(stage_continue), 64'(e_cont));
      chk({tag, ".ap_ready"}, 64'(ap_ready), 64'(zero ? (t == 1) : (t == last_r + 1)));
      chk({tag, ".ap_done"}, 64'(ap_done), 64'(t >= donec && t <= c));
      chk({tag, ".ap_idle"}, 64'(ap_idle), 64'(t == 0 || t == c + 1));
`ifndef USERDMA_CTRL_WATCHDOG_EN
      chk({tag, ".stall_flag"}, 64'(stall_flag), 64'd0);
`endif
      if (t == c + 1) begin
        chk({tag, ".run_mode"}, 64'(run_mode), 64'(mode));
        chk({tag, ".run_len"}, 64'(run_len), 64'(len));
        chk({tag, ".zero_run"}, 64'(zero_run), 64'(zero));
      end
    end
    stage_ready = 5'b0;
    stage_done  = 5'b0;
    ap_continue = 1'b0;
    if (!hold_start) ap_start = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge ap_clk);
    #1;
    chk_reset_vals("reset");
    ap_rst_n = 1'b1;

    // S2MM only: stages 0..2 ready with start, done 10/50/300 cycles later.
    rdly = '{0, 0, 0, 0, 0};
    ddly = '{10, 50, 300, 0, 0};
    run_launch(2'b01, 32'd256, 0, 1'b0, "s2mm");

    // Both directions, stage 4 ready held off for 20 cycles.
    rdly = '{0, 1, 2, 0, 20};
    ddly = '{3, 5, 2, 4, 1};
    run_launch(2'b11, 32'd64, 1, 1'b0, "both_slow4");

    rdly = '{0, 0, 0, 0, 0};
    ddly = '{1, 1, 1, 1, 1};
    run_launch(2'b00, 32'd5, 0, 1'b0, "zero_mode");
    run_launch(2'b01, 32'd0, 2, 1'b0, "zero_len");

    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 5; i++) begin
        rdly[i] = $urandom_range(0, 6);
        ddly[i] = $urandom_range(0, 8);
      end
      run_launch(2'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom,
                 $urandom_range(0, 3), 1'b0, "rand");
    end

    // ap_continue withheld 15 cycles with ap_start held: relaunch only after IDLE.
    rdly = '{0, 2, 0, 1, 3};
    ddly = '{4, 0, 0, 2, 5};
    run_launch(2'b10, 32'd9, 14, 1'b1, "hold");
    @(posedge ap_clk);
    #1;
    stage_ready = 5'b01001;
    #3;
    chk("relaunch.stage_start", 64'(stage_start), 64'(MM2S));
    chk("relaunch.ap_idle", 64'(ap_idle), 64'd0);
    @(posedge ap_clk);
    #1;
    stage_ready = 5'b0;
    ap_start = 1'b0;
    #3;
    chk("abort.pending", 64'(stage_start), 64'h10);
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk_reset_vals("abort");
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;

`ifdef USERDMA_CTRL_WATCHDOG_EN
    @(posedge ap_clk);
    #1;
    ap_start = 1'b1;
    cfg_mode = 2'b01;
    cfg_len  = 32'd4;
    @(posedge ap_clk);
    #1;
    ap_start = 1'b0;
    stage_ready = 5'b00111;
    @(posedge ap_clk);
    #1;
    stage_ready = 5'b0;
    stage_done = 5'b00011;
    for (int t = 3; t <= 19; t++) begin
      @(posedge ap_clk);
      #1;
      stage_done = 5'b0;
      #3;
      if (t == 18) chk("wdog.before", 64'(stall_flag), 64'd0);
      if (t == 19) begin
        chk("wdog.flag", 64'(stall_flag), 64'd1);
        chk("wdog.stages", 64'(stall_stages), 64'h04);
      end
    end
    ap_rst_n = 1'b0;
    #1;
    chk_reset_vals("wdog_reset");
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
`endif

    repeat (2) @(posedge ap_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
